// File: rtl/spi_cmd_seq_pkg.sv
// Shared state encoding, lane-mode constants and address byte selection for the SPI command sequencer.
package spi_cmd_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_OPCODE,
    ST_ADDR,
    ST_DUMMY,
    ST_DATA,
    ST_DRAIN,
    ST_FINISH
  } state_t;

  localparam logic [1:0] MODE_EXT  = 2'b00;
  localparam logic [1:0] MODE_DUAL = 2'b01;
  localparam logic [1:0] MODE_QUAD = 2'b10;

  // n counts address bytes still to send, so the MSB-first byte is selected by the remaining count
  function automatic logic [7:0] addr_byte(input logic [23:0] addr, input logic [1:0] n);
    case (n)
      2'd3:    addr_byte = addr[23:16];
      2'd2:    addr_byte = addr[15:8];
      default: addr_byte = addr[7:0];
    endcase
  endfunction

endpackage

// File: rtl/spi_cmd_seq.sv
// Expands one flash command descriptor into opcode/address/dummy/data items for spi_tr8; next item is loaded 1 cycle after tr_done.
// Descriptors are taken only when idle (no queueing); TX underrun and RX overflow abort/drop and raise sticky error flags.
module spi_cmd_seq
  import spi_cmd_seq_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [7:0]       cmd_opcode,
  input  logic [23:0]      cmd_addr,
  input  logic [1:0]       cmd_addr_bytes,
  input  logic [3:0]       cmd_dummy_clks,
  input  logic             cmd_rnw,
  input  logic [CNT_W-1:0] cmd_len,
  input  logic [1:0]       cmd_mode_op,
  input  logic [1:0]       cmd_mode_addr,
  input  logic [1:0]       cmd_mode_data,
  input  logic [7:0]       tx_data,
  input  logic             tx_empty,
  output logic             tx_rd_en,
  output logic [7:0]       rx_data,
  input  logic             rx_full,
  output logic             rx_wr_en,
  output logic             tr_start,
  output logic             tr_rnw,
  output logic             tr_dummy,
  output logic [7:0]       tr_din,
  output logic [1:0]       tr_mode,
  output logic [3:0]       tr_dummy_clks,
  input  logic             tr_done,
  input  logic             tr_rd_valid,
  input  logic [7:0]       tr_dout,
  input  logic             tr_sel,
  output logic             busy,
  output logic             cmd_done,
  output logic             err_underrun,
  output logic             err_overflow
);

  state_t           state, state_nxt;
  logic [23:0]      addr, addr_nxt;
  logic [1:0]       addr_cnt, addr_cnt_nxt;
  logic             rd_cmd, rd_cmd_nxt;
  logic [1:0]       mode_addr, mode_addr_nxt;
  logic [1:0]       mode_data, mode_data_nxt;
  logic [CNT_W-1:0] len, len_nxt;
  logic [CNT_W-1:0] data_left, data_left_nxt;
  logic [CNT_W-1:0] rcvd, rcvd_nxt;

  logic             cmd_ready_nxt, busy_nxt, cmd_done_nxt;
  logic             err_underrun_nxt, err_overflow_nxt;
  logic             tx_rd_en_nxt, rx_wr_en_nxt;
  logic [7:0]       rx_data_nxt, tr_din_nxt;
  logic             tr_start_nxt, tr_rnw_nxt, tr_dummy_nxt;
  logic [1:0]       tr_mode_nxt;
  logic [3:0]       tr_dummy_clks_nxt;
  logic             load_addr, load_dummy, load_data, end_items;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      addr          <= '0;
      addr_cnt      <= '0;
      rd_cmd        <= 1'b0;
      mode_addr     <= MODE_EXT;
      mode_data     <= MODE_EXT;
      len           <= '0;
      data_left     <= '0;
      rcvd          <= '0;
      cmd_ready     <= 1'b1;
      busy          <= 1'b0;
      cmd_done      <= 1'b0;
      err_underrun  <= 1'b0;
      err_overflow  <= 1'b0;
      tx_rd_en      <= 1'b0;
      rx_wr_en      <= 1'b0;
      rx_data       <= '0;
      tr_start      <= 1'b0;
      tr_rnw        <= 1'b0;
      tr_dummy      <= 1'b0;
      tr_din        <= '0;
      tr_mode       <= MODE_EXT;
      tr_dummy_clks <= '0;
    end else begin
      state         <= state_nxt;
      addr          <= addr_nxt;
      addr_cnt      <= addr_cnt_nxt;
      rd_cmd        <= rd_cmd_nxt;
      mode_addr     <= mode_addr_nxt;
      mode_data     <= mode_data_nxt;
      len           <= len_nxt;
      data_left     <= data_left_nxt;
      rcvd          <= rcvd_nxt;
      cmd_ready     <= cmd_ready_nxt;
      busy          <= busy_nxt;
      cmd_done      <= cmd_done_nxt;
      err_underrun  <= err_underrun_nxt;
      err_overflow  <= err_overflow_nxt;
      tx_rd_en      <= tx_rd_en_nxt;
      rx_wr_en      <= rx_wr_en_nxt;
      rx_data       <= rx_data_nxt;
      tr_start      <= tr_start_nxt;
      tr_rnw        <= tr_rnw_nxt;
      tr_dummy      <= tr_dummy_nxt;
      tr_din        <= tr_din_nxt;
      tr_mode       <= tr_mode_nxt;
      tr_dummy_clks <= tr_dummy_clks_nxt;
    end
  end

  always_comb begin
    state_nxt         = state;
    addr_nxt          = addr;
    addr_cnt_nxt      = addr_cnt;
    rd_cmd_nxt        = rd_cmd;
    mode_addr_nxt     = mode_addr;
    mode_data_nxt     = mode_data;
    len_nxt           = len;
    data_left_nxt     = data_left;
    rcvd_nxt          = rcvd;
    cmd_done_nxt      = 1'b0;
    err_underrun_nxt  = err_underrun;
    err_overflow_nxt  = err_overflow;
    tx_rd_en_nxt      = 1'b0;
    rx_wr_en_nxt      = 1'b0;
    rx_data_nxt       = rx_data;
    tr_start_nxt      = tr_start;
    tr_rnw_nxt        = tr_rnw;
    tr_dummy_nxt      = tr_dummy;
    tr_din_nxt        = tr_din;
    tr_mode_nxt       = tr_mode;
    tr_dummy_clks_nxt = tr_dummy_clks;
    load_addr         = 1'b0;
    load_dummy        = 1'b0;
    load_data         = 1'b0;
    end_items         = 1'b0;

    // addr_cnt and data_left count items not yet loaded, so every phase falls through the same chain
    unique case (state)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          state_nxt         = ST_OPCODE;
          addr_nxt          = cmd_addr;
          addr_cnt_nxt      = cmd_addr_bytes;
          rd_cmd_nxt        = cmd_rnw;
          mode_addr_nxt     = cmd_mode_addr;
          mode_data_nxt     = cmd_mode_data;
          len_nxt           = cmd_len;
          data_left_nxt     = cmd_len;
          rcvd_nxt          = '0;
          err_underrun_nxt  = 1'b0;
          err_overflow_nxt  = 1'b0;
          tr_start_nxt      = 1'b1;
          tr_din_nxt        = cmd_opcode;
          tr_mode_nxt       = cmd_mode_op;
          tr_rnw_nxt        = 1'b0;
          tr_dummy_nxt      = 1'b0;
          tr_dummy_clks_nxt = cmd_dummy_clks;
        end
      end
      ST_OPCODE, ST_ADDR: begin
        if (tr_done) begin
          if (addr_cnt != 2'd0)          load_addr  = 1'b1;
          else if (tr_dummy_clks != 4'd0) load_dummy = 1'b1;
          else if (data_left != '0)       load_data  = 1'b1;
          else                            end_items  = 1'b1;
        end
      end
      ST_DUMMY, ST_DATA: begin
        if (tr_done) begin
          if (data_left != '0) load_data = 1'b1;
          else                 end_items = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (tr_sel && (!rd_cmd || rcvd == len)) begin
          state_nxt    = ST_FINISH;
          cmd_done_nxt = 1'b1;
        end
      end
      ST_FINISH: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase

    if (load_addr) begin
      state_nxt    = ST_ADDR;
      tr_din_nxt   = addr_byte(addr, addr_cnt);
      tr_mode_nxt  = mode_addr;
      tr_rnw_nxt   = 1'b0;
      tr_dummy_nxt = 1'b0;
      addr_cnt_nxt = addr_cnt - 2'd1;
    end

    if (load_dummy) begin
      state_nxt    = ST_DUMMY;
      tr_din_nxt   = '0;
      tr_mode_nxt  = mode_addr;
      tr_rnw_nxt   = 1'b0;
      tr_dummy_nxt = 1'b1;
    end

    if (load_data) begin
      state_nxt     = ST_DATA;
      tr_mode_nxt   = mode_data;
      tr_dummy_nxt  = 1'b0;
      data_left_nxt = data_left - CNT_W'(1);
      if (rd_cmd) begin
        tr_rnw_nxt = 1'b1;
        tr_din_nxt = '0;
      end else if (tx_empty) begin
        err_underrun_nxt = 1'b1;
        tr_start_nxt     = 1'b0;
        state_nxt        = ST_DRAIN;
      end else begin
        tr_rnw_nxt   = 1'b0;
        tr_din_nxt   = tx_data;
        tx_rd_en_nxt = 1'b1;
      end
    end

    if (end_items) begin
      tr_start_nxt = 1'b0;
      tr_dummy_nxt = 1'b0;
      state_nxt    = ST_DRAIN;
    end

    // a byte dropped on a full RX FIFO still counts, otherwise DRAIN would never complete
    if ((state == ST_DATA || state == ST_DRAIN) && tr_rd_valid) begin
      rcvd_nxt = rcvd + CNT_W'(1);
      if (rx_full) begin
        err_overflow_nxt = 1'b1;
      end else begin
        rx_wr_en_nxt = 1'b1;
        rx_data_nxt  = tr_dout;
      end
    end

    cmd_ready_nxt = (state_nxt == ST_IDLE);
    busy_nxt      = (state_nxt != ST_IDLE);
  end

endmodule
